// File: rtl/uart_tx_framed.sv
// Parametrised UART transmitter: TX FIFO, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_BREAK_EN to add the break_req input and a line-break state entered from IDLE.
module uart_tx_framed #(
  parameter int ClockDivider = 10,
  parameter int DataBits     = 8,
  parameter int Parity       = 0,
  parameter int StopBits     = 1,
  parameter int Depth        = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DataBits-1:0]    data_in,
  input  logic                   data_in_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                   break_req,
`endif
  output logic                   ready,
  output logic                   out_bit,
  output logic                   busy,
  output logic [$clog2(Depth):0] fifo_level
);
  localparam int TW = $clog2(ClockDivider);
  localparam int PW = $clog2(Depth);
  localparam int LW = PW + 1;
`ifdef UART_TX_BREAK_EN
  localparam int FrameLen = ClockDivider * (1 + DataBits + ((Parity != 0) ? 1 : 0) + StopBits);
  localparam int BKW      = $clog2(FrameLen);
`endif

  if (ClockDivider < 2 || DataBits < 5 || DataBits > 8 || Parity < 0 || Parity > 2 ||
      StopBits < 1 || StopBits > 2 || Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_params
    $error("uart_tx_framed: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_BREAK_EN
    , BREAK
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [2:0]          bit_q, bit_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                out_q, out_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [DataBits-1:0] mem_q [Depth];
`ifdef UART_TX_BREAK_EN
  logic [BKW-1:0]      brk_q, brk_d;
`endif
  logic                push, pop, timer_end;
  logic [DataBits-1:0] head;

  assign timer_end = (timer_q == TW'(ClockDivider - 1));
  assign head      = mem_q[rd_ptr_q];

  // Ready comes from the registered count only, so a same-cycle pop never opens a full FIFO.
  assign ready      = (level_q != LW'(Depth));
  assign busy       = (state_q != IDLE) || (level_q != '0);
  assign fifo_level = level_q;
  assign out_bit    = out_q;

  always_comb begin
    push     = data_in_valid && ready;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_end ? '0 : timer_q + TW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_d   = brk_q;
`endif
    case (state_q)
      IDLE: begin
        timer_d = '0;
        bit_d   = '0;
`ifdef UART_TX_BREAK_EN
        brk_d   = '0;
        if (break_req) state_d = BREAK;
        else
`endif
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (timer_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (timer_end) begin
          if (bit_q == 3'(DataBits - 1)) begin
            bit_d   = '0;
            state_d = (Parity != 0) ? PARITY : STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (timer_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more words are queued.
        if (timer_end) begin
          if (bit_q == 3'(StopBits - 1)) begin
            bit_d = '0;
            if (level_q != '0) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        timer_d = '0;
        if (brk_q != BKW'(FrameLen - 1)) brk_d = brk_q + BKW'(1);
        else if (!break_req) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shift_d = head;
      par_d   = (^head) ^ 1'(Parity == 1);
    end

    // The line is registered from next-state values so the pin never glitches.
    case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = shift_d[0];
      PARITY:  out_d = par_d;
`ifdef UART_TX_BREAK_EN
      BREAK:   out_d = 1'b0;
`endif
      default: out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      out_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
`ifdef UART_TX_BREAK_EN
      brk_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      out_q    <= out_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
`ifdef UART_TX_BREAK_EN
      brk_q    <= brk_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
    if (push) mem_q[wr_ptr_q] <= data_in;
  end
endmodule

// File: tb/tb_uart_tx_framed.sv
// Self-checking bench for uart_tx_framed: 8N1 main instance plus 7E2 and 7O2 instances.
module tb_uart_tx_framed;
  localparam int CD = 10;
  localparam int FL = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       ready, out_bit, busy;
  logic [2:0] fifo_level;
  logic [6:0] p_data = 7'h00;
  logic       p_valid = 1'b0;
  logic       e_ready, e_out, e_busy, o_ready, o_out, o_busy;
  logic [2:0] e_level, o_level;
`ifdef UART_TX_BREAK_EN
  logic       break_req = 1'b0;
  logic       no_brk = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] got_w [$];
  int           got_gap [$];

  always #5 clk = ~clk;

  uart_tx_framed #(.ClockDivider(CD), .DataBits(8), .Parity(0), .StopBits(1), .Depth(4)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .ready(ready), .out_bit(out_bit), .busy(busy), .fifo_level(fifo_level));

  uart_tx_framed #(.ClockDivider(CD), .DataBits(7), .Parity(2), .StopBits(2), .Depth(4)) u_even (
    .clk(clk), .rst(rst), .data_in(p_data), .data_in_valid(p_valid),
`ifdef UART_TX_BREAK_EN
    .break_req(no_brk),
`endif
    .ready(e_ready), .out_bit(e_out), .busy(e_busy), .fifo_level(e_level));

  uart_tx_framed #(.ClockDivider(CD), .DataBits(7), .Parity(1), .StopBits(2), .Depth(4)) u_odd (
    .clk(clk), .rst(rst), .data_in(p_data), .data_in_valid(p_valid),
`ifdef UART_TX_BREAK_EN
    .break_req(no_brk),
`endif
    .ready(o_ready), .out_bit(o_out), .busy(o_busy), .fifo_level(o_level));

  // Expected line, one entry per clock: start, data LSB first, optional parity, stop bits.
  function automatic logic [127:0] frame_wave(input logic [7:0] d, input int nb, input int par,
                                              input int sb);
    logic [15:0]  bits;
    logic         p;
    logic [127:0] w;
    int           n;
    bits = '0; p = 1'b0; w = '0;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nb; i++) begin
      bits[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (par != 0) begin
      bits[n] = (par == 1) ? ~p : p;
      n++;
    end
    for (int i = 0; i < sb; i++) begin
      bits[n] = 1'b1;
      n++;
    end
    for (int c = 0; c < n * CD; c++) w[c] = bits[c / CD];
    return w;
  endfunction

  task automatic push(input logic [7:0] d, output bit ok);
    int t;
    t = 0; ok = 1'b0;
    data_in = d;
    data_in_valid = 1'b1;
    while (t < 2000) begin
      @(negedge clk);
      if (ready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
      t++;
    end
    data_in_valid = 1'b0;
  endtask

  // Records n frames of the main line; gap is the count of idle samples before each start bit.
  task automatic collect_frames(input int n);
    logic [127:0] w;
    int gap;
    got_w.delete();
    got_gap.delete();
    for (int f = 0; f < n; f++) begin
      gap = 0;
      @(negedge clk);
      while (out_bit !== 1'b0 && gap < 2000) begin
        gap++;
        @(negedge clk);
      end
      if (gap >= 2000) return;
      w = '0;
      w[0] = out_bit;
      for (int c = 1; c < FL; c++) begin
        @(negedge clk);
        w[c] = out_bit;
      end
      got_w.push_back(w);
      got_gap.push_back(gap);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_bit !== 1'b1) begin n_bad++; $display("FAIL reset_out_bit got %b want 1", out_bit); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    n_cmp++; if ({e_out, o_out, e_ready, o_ready} !== 4'b1111) begin
      n_bad++; $display("FAIL reset_par_inst got %b want 1111", {e_out, o_out, e_ready, o_ready});
    end
    n_cmp++; if ({e_level, o_level, e_busy, o_busy} !== 8'h00) begin
      n_bad++; $display("FAIL reset_par_level got %h want 00", {e_level, o_level, e_busy, o_busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [127:0] w, bz, exp;
    @(posedge clk); #1;
    data_in = 8'h48;
    data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_bit !== 1'b1) begin n_bad++; $display("FAIL single_latency got %b want 1", out_bit); end
    n_cmp++; if (fifo_level !== 3'd1) begin n_bad++; $display("FAIL single_level got %0d want 1", fifo_level); end
    w = '0; bz = '0;
    for (int c = 0; c < FL; c++) begin
      @(negedge clk);
      w[c] = out_bit;
      bz[c] = busy;
    end
    exp = frame_wave(8'h48, 8, 0, 1);
    n_cmp++; if (w !== exp) begin n_bad++; $display("FAIL single_frame got %h want %h", w, exp); end
    n_cmp++; if (bz[FL-1] !== 1'b1) begin n_bad++; $display("FAIL single_busy_last got %b want 1", bz[FL-1]); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_parity;
    logic [6:0]   d;
    logic [127:0] we, wo, xe, xo;
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? 7'h41 : 7'($urandom);
      p_data = d;
      p_valid = 1'b1;
      @(posedge clk); #1;
      p_valid = 1'b0;
      @(negedge clk);
      we = '0; wo = '0;
      for (int c = 0; c < 110; c++) begin
        @(negedge clk);
        we[c] = e_out;
        wo[c] = o_out;
      end
      xe = frame_wave({1'b0, d}, 7, 2, 2);
      xo = frame_wave({1'b0, d}, 7, 1, 2);
      n_cmp++; if (we !== xe) begin n_bad++; $display("FAIL parity_even_frame d=%h got %h want %h", d, we, xe); end
      n_cmp++; if (wo !== xo) begin n_bad++; $display("FAIL parity_odd_frame d=%h got %h want %h", d, wo, xo); end
      if (k == 0) begin
        n_cmp++; if ({we[85], wo[85]} !== 2'b01) begin
          n_bad++; $display("FAIL parity_bit_0x41 got even=%b odd=%b want even=0 odd=1", we[85], wo[85]);
        end
      end
      @(negedge clk);
      n_cmp++; if ({e_busy, o_busy} !== 2'b00) begin
        n_bad++; $display("FAIL parity_length busy got %b want 00", {e_busy, o_busy});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_burst;
    logic [7:0] msg [12] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20,
                             8'h77, 8'h6f, 8'h72, 8'h6c, 8'h64, 8'h0a};
    logic [127:0] exp;
    bit acc, saw_full;
    int t;
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          data_in = msg[i];
          data_in_valid = 1'b1;
          acc = 1'b0; t = 0;
          while (!acc && t < 3000) begin
            @(negedge clk);
            n_cmp++;
            if (ready !== (fifo_level != 3'd4)) begin
              n_bad++; $display("FAIL burst_ready got %b level=%0d", ready, fifo_level);
            end
            if (fifo_level == 3'd4) saw_full = 1'b1;
            acc = ready;
            @(posedge clk); #1;
            t++;
          end
        end
        data_in_valid = 1'b0;
      end
      collect_frames(12);
    join
    n_cmp++; if (saw_full !== 1'b1) begin n_bad++; $display("FAIL burst_full got %b want 1", saw_full); end
    n_cmp++; if (got_w.size() != 12) begin n_bad++; $display("FAIL burst_count got %0d want 12", got_w.size()); end
    for (int i = 0; i < got_w.size() && i < 12; i++) begin
      exp = frame_wave(msg[i], 8, 0, 1);
      n_cmp++; if (got_w[i] !== exp) begin n_bad++; $display("FAIL burst_frame%0d got %h want %h", i, got_w[i], exp); end
      if (i > 0) begin
        n_cmp++; if (got_gap[i] != 0) begin n_bad++; $display("FAIL burst_gap%0d got %0d want 0", i, got_gap[i]); end
      end
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_full_boundary;
    logic [7:0] w [6];
    logic [127:0] exp;
    logic [2:0] prev_level;
    bit ok, rose;
    int idx;
    for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
    prev_level = 3'd0;
    fork
      begin
        for (int i = 0; i < 5; i++) push(w[i], ok);
        @(negedge clk);
        n_cmp++; if ({ready, fifo_level} !== 4'b0100) begin
          n_bad++; $display("FAIL full_level got ready=%b level=%0d want ready=0 level=4", ready, fifo_level);
        end
        data_in = w[5];
        data_in_valid = 1'b1;
        idx = 0; rose = 1'b0;
        while (idx < 300) begin
          @(negedge clk);
          if (ready) begin rose = 1'b1; break; end
          prev_level = fifo_level;
          idx++;
          @(posedge clk); #1;
        end
        n_cmp++; if (idx != 96 || prev_level !== 3'd4) begin
          n_bad++; $display("FAIL full_refuse got idx=%0d prev_level=%0d want idx=96 prev_level=4", idx, prev_level);
        end
        n_cmp++; if (fifo_level !== 3'd3) begin n_bad++; $display("FAIL full_after_pop got %0d want 3", fifo_level); end
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({ready, fifo_level} !== 4'b0100) begin
          n_bad++; $display("FAIL full_refill got ready=%b level=%0d want ready=0 level=4 rose=%b", ready, fifo_level, rose);
        end
      end
      collect_frames(6);
    join
    n_cmp++; if (got_w.size() != 6) begin n_bad++; $display("FAIL full_count got %0d want 6", got_w.size()); end
    for (int i = 0; i < got_w.size() && i < 6; i++) begin
      exp = frame_wave(w[i], 8, 0, 1);
      n_cmp++; if (got_w[i] !== exp) begin n_bad++; $display("FAIL full_frame%0d got %h want %h", i, got_w[i], exp); end
      if (i > 0) begin
        n_cmp++; if (got_gap[i] != 0) begin n_bad++; $display("FAIL full_gap%0d got %0d want 0", i, got_gap[i]); end
      end
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [7:0] nw;
    logic [127:0] exp;
    bit ok;
    int lows;
    push(8'($urandom), ok);
    push(8'h00, ok);
    push(8'($urandom), ok);
    repeat (150) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_bit !== 1'b0) begin n_bad++; $display("FAIL midrst_pre got %b want 0", out_bit); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({out_bit, ready, busy, fifo_level} !== 6'b110000) begin
      n_bad++; $display("FAIL midrst_state got out=%b ready=%b busy=%b level=%0d want 1 1 0 0",
                        out_bit, ready, busy, fifo_level);
    end
    nw = 8'($urandom);
    @(posedge clk); #1;
    push(nw, ok);
    collect_frames(1);
    exp = frame_wave(nw, 8, 0, 1);
    n_cmp++; if (got_w.size() != 1 || got_w[0] !== exp) begin
      n_bad++; $display("FAIL midrst_new_word frames=%0d want 1 frame %h", got_w.size(), exp);
    end
    lows = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (out_bit !== 1'b1) lows++;
    end
    n_cmp++; if (lows != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midrst_quiet got lows=%0d busy=%b want 0 0", lows, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] sent [$];
    logic [7:0] d;
    logic [127:0] exp;
    bit ok;
    int k;
    sent.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          d = 8'($urandom);
          k = $urandom_range(0, 3);
          repeat (k) begin @(posedge clk); #1; end
          push(d, ok);
          if (ok) sent.push_back(d);
        end
      end
      collect_frames(10);
    join
    n_cmp++; if (got_w.size() != sent.size()) begin
      n_bad++; $display("FAIL b2b_count got %0d want %0d", got_w.size(), sent.size());
    end
    for (int i = 0; i < got_w.size() && i < sent.size(); i++) begin
      exp = frame_wave(sent[i], 8, 0, 1);
      n_cmp++; if (got_w[i] !== exp) begin n_bad++; $display("FAIL b2b_frame%0d got %h want %h", i, got_w[i], exp); end
      if (i > 0) begin
        n_cmp++; if (got_gap[i] != 0) begin n_bad++; $display("FAIL b2b_gap%0d got %0d want 0", i, got_gap[i]); end
      end
    end
    repeat (3) @(posedge clk); #1;
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break;
    logic [7:0] d;
    logic [127:0] w, exp;
    bit ok, mid_ok;
    d = 8'($urandom);
    data_in = d;
    data_in_valid = 1'b1;
    break_req = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    w = '0; mid_ok = 1'b1;
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      w[c] = out_bit;
      if (c == 4) break_req = 1'b0;
      if (c == 50 && (fifo_level !== 3'd1 || busy !== 1'b1)) mid_ok = 1'b0;
    end
    exp = '0;
    for (int c = 100; c < 110; c++) exp[c] = 1'b1;
    n_cmp++; if (w !== exp) begin n_bad++; $display("FAIL break_line got %h want %h", w, exp); end
    n_cmp++; if (mid_ok !== 1'b1) begin n_bad++; $display("FAIL break_fifo_kept got %b want 1", mid_ok); end
    w = '0;
    for (int c = 0; c < FL; c++) begin @(negedge clk); w[c] = out_bit; end
    exp = frame_wave(d, 8, 0, 1);
    n_cmp++; if (w !== exp) begin n_bad++; $display("FAIL break_then_word got %h want %h", w, exp); end
    repeat (5) @(posedge clk); #1;
    d = 8'($urandom);
    push(d, ok);
    @(negedge clk);
    w = '0;
    for (int c = 0; c < FL; c++) begin
      @(negedge clk);
      w[c] = out_bit;
      if (c == 30) break_req = 1'b1;
    end
    n_cmp++; if (w !== exp) begin end
    exp = frame_wave(d, 8, 0, 1);
    n_cmp++; if (w !== exp) begin n_bad++; $display("FAIL break_mid_frame got %h want %h", w, exp); end
    @(negedge clk);
    w = '0;
    for (int c = 0; c < FL; c++) begin
      @(negedge clk);
      w[c] = out_bit;
      if (c == 20) break_req = 1'b0;
    end
    n_cmp++; if (w !== 128'h0) begin n_bad++; $display("FAIL break_after_frame got %h want 0", w); end
    @(negedge clk);
    n_cmp++; if (out_bit !== 1'b1) begin n_bad++; $display("FAIL break_stop got %b want 1", out_bit); end
    repeat (10) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL break_end_busy got %b want 0", busy); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    repeat (3) @(posedge clk); #1;
    test_single();
    test_parity();
    test_burst();
    test_full_boundary();
    test_reset_mid();
    test_back_to_back();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
